// File: rtl/kypd_pkg.sv
// kypd_pkg: shared constants and types for the keypad-to-UART bridge.
//   KEYMAP   - ASCII byte sent for each key index k = {row,col}
//   uart_state_t - 8N1 transmitter states
//   BIT_DIV / DWELL - defaults for the 12 MHz / 9600 baud / 1 kHz scan build
//   cnt_w()  - counter width helper that never returns zero
package kypd_pkg;

    localparam int CLK_HZ_DEF  = 12000000;
    localparam int BAUD_DEF    = 9600;
    localparam int SCAN_HZ_DEF = 1000;
    localparam int BIT_DIV     = CLK_HZ_DEF / BAUD_DEF;
    localparam int DWELL       = CLK_HZ_DEF / SCAN_HZ_DEF;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // Row-major legend: r0 "123A", r1 "456B", r2 "789C", r3 "0FED"
    localparam logic [7:0] KEYMAP [16] = '{
        8'h31, 8'h32, 8'h33, 8'h41,
        8'h34, 8'h35, 8'h36, 8'h42,
        8'h37, 8'h38, 8'h39, 8'h43,
        8'h30, 8'h46, 8'h45, 8'h44
    };

    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/pmod_kypd_tx_uart.sv
// uart_tx: reusable 8N1 serial transmitter.
//   CLK, RST_N - clock, async active-low reset
//   start      - launch a frame with data (accepted only while idle)
//   data[7:0]  - byte to send, LSB first
//   TX         - serial line, idle high
//   busy       - high for the whole 10*BIT_DIV-cycle frame
module uart_tx
    import kypd_pkg::*;
#(
    parameter int BIT_DIV = kypd_pkg::BIT_DIV
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       busy
);

    localparam int CW = cnt_w(BIT_DIV);

    uart_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          bit_end;

    assign bit_end = (cnt == CW'(BIT_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= UART_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        TX        = 1'b1;
        busy      = (state != UART_IDLE);
        case (state)
            UART_IDLE: begin
                if (start) begin
                    state_n = UART_START;
                    cnt_n   = '0;
                    shreg_n = data;
                end
            end
            UART_START: begin
                TX = 1'b0;
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = UART_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            UART_DATA: begin
                TX = shreg[0];
                if (bit_end) begin
                    cnt_n     = '0;
                    shreg_n   = shreg >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = UART_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = UART_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/pmod_kypd_tx.sv
// pmod_kypd_tx: scans a 4x4 Pmod keypad, debounces it, and sends one ASCII
// byte over UART for every new key press.
//   CLK, RST_N - clock, async active-low reset
//   COL[3:0]   - column drive, active low, one column low at a time
//   ROW[3:0]   - row sense, active low, asynchronous
//   TX         - UART 8N1 serial out
//   KEYS[15:0] - debounced key-down mask, bit k = {row,col}
//   TX_BUSY    - UART frame in progress
module pmod_kypd_tx
    import kypd_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int SCAN_HZ    = 1000,
    parameter int DEB_SWEEPS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [3:0]  COL,
    input  logic [3:0]  ROW,
    output logic        TX,
    output logic [15:0] KEYS,
    output logic        TX_BUSY
);

    localparam int BDIV      = CLK_HZ / BAUD;
    localparam int DWELL_CYC = CLK_HZ / SCAN_HZ;
    localparam int DCW       = cnt_w(DWELL_CYC);
    localparam int SCW       = cnt_w(DEB_SWEEPS);

    logic [3:0]     row_s1, row_s2;
    logic [DCW-1:0] dwell_cnt;
    logic [1:0]     col_idx;
    logic [15:0]    snap, snap_new, prev_snap, pending, rise, pend_clr;
    logic [SCW-1:0] stable_cnt, stable_nxt;
    logic           dwell_end, sweep_end, keys_load;
    logic           launch, uart_busy;
    logic [7:0]     launch_byte;

    assign COL       = ~(4'b0001 << col_idx);
    assign dwell_end = (dwell_cnt == DCW'(DWELL_CYC - 1));
    assign sweep_end = dwell_end && (col_idx == 2'd3);

    // Current column's rows merged into the snapshot; only committed on dwell_end.
    always_comb begin
        snap_new = snap;
        for (int r = 0; r < 4; r++)
            snap_new[{r[1:0], col_idx}] = ~row_s2[r];
    end

    // Count of consecutive identical sweeps, saturating at the accept threshold.
    always_comb begin
        stable_nxt = '0;
        if (snap_new == prev_snap)
            stable_nxt = (stable_cnt == SCW'(DEB_SWEEPS - 1)) ? stable_cnt : stable_cnt + 1'b1;
    end

    assign keys_load = sweep_end && (stable_nxt == SCW'(DEB_SWEEPS - 1));
    assign rise      = keys_load ? (snap_new & ~KEYS) : 16'h0000;

    // Lowest pending index wins; descending loop so the last hit is the lowest.
    always_comb begin
        pend_clr    = '0;
        launch      = 1'b0;
        launch_byte = KEYMAP[0];
        if (!uart_busy && pending != 16'h0000) begin
            launch = 1'b1;
            for (int k = 15; k >= 0; k--) begin
                if (pending[k]) begin
                    pend_clr    = 16'd1 << k;
                    launch_byte = KEYMAP[k];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            dwell_cnt  <= '0;
            col_idx    <= '0;
            snap       <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
            KEYS       <= '0;
            pending    <= '0;
        end else begin
            row_s1 <= ROW;
            row_s2 <= row_s1;
            if (dwell_end) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                snap      <= snap_new;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            if (sweep_end) begin
                prev_snap  <= snap_new;
                stable_cnt <= stable_nxt;
            end
            if (keys_load) KEYS <= snap_new;
            // A new press landing on the bit being dispatched keeps it pending.
            pending <= (pending & ~pend_clr) | rise;
        end
    end

    uart_tx #(.BIT_DIV(BDIV)) u_uart (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (launch),
        .data  (launch_byte),
        .TX    (TX),
        .busy  (uart_busy)
    );

    assign TX_BUSY = uart_busy;

endmodule

// File: tb/tb_pmod_kypd_tx.sv
module tb_pmod_kypd_tx;

    localparam int BDIV  = 16;
    localparam int SWEEP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col, row;
    logic        tx, tx_busy;
    logic [15:0] keys;
    logic [15:0] pressed = 16'h0000;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] exp_q[$];
    bit   tx_seen = 1'b0;

    always #5 clk = ~clk;

    pmod_kypd_tx #(.CLK_HZ(1600), .BAUD(100), .SCAN_HZ(400), .DEB_SWEEPS(2)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .COL     (col),
        .ROW     (row),
        .TX      (tx),
        .KEYS    (keys),
        .TX_BUSY (tx_busy)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_keys(input logic [15:0] v, input int bound, input string name);
        for (int i = 0; i < bound && keys !== v; i++) @(negedge clk);
        check(name, keys, v);
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound && (exp_q.size() != 0 || tx_busy !== 1'b0); i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // UART monitor: mid-bit sampling, frames cut by reset are discarded.
    initial begin
        logic [7:0] b;
        logic       st, sp;
        bit         abort;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge tx);
            if (rst_n !== 1'b1) continue;
            tx_seen = 1'b1;
            abort   = 1'b0;
            repeat (BDIV/2) @(posedge clk);
            #1 st = tx;
            if (!rst_n) abort = 1'b1;
            for (int i = 0; i < 8; i++) begin
                repeat (BDIV) @(posedge clk);
                #1 b[i] = tx;
                if (!rst_n) abort = 1'b1;
            end
            repeat (BDIV) @(posedge clk);
            #1 sp = tx;
            if (!rst_n) abort = 1'b1;
            if (!abort) begin
                check("frame_start", st, 1'b0);
                check("frame_stop", sp, 1'b1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %0h expected none", b);
                end else begin
                    check("frame_data", b, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  keys_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_tx", tx, 1'b1);
        check("rst_keys", keys, 16'h0000);
        check("rst_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("scan_col0", col, 4'b1110);
        @(negedge clk);
        check("scan_col1", col, 4'b1101);
        repeat (4) @(negedge clk);
        check("scan_col2", col, 4'b1011);
        repeat (4) @(negedge clk);
        check("scan_col3", col, 4'b0111);
        repeat (4) @(negedge clk);
        check("scan_wrap", col, 4'b1110);

        // Key 5 -> '5'
        pressed = 16'h0020;
        exp_q.push_back(8'h35);
        wait_keys(16'h0020, 6*SWEEP, "key5_keys");
        lat = 0;
        while (tx !== 1'b0 && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check("key5_launch_lat", (lat >= 1 && lat <= 2), 1'b1);
        wait_idle(400, "key5_sent");
        pressed = 16'h0000;
        wait_keys(16'h0000, 6*SWEEP, "key5_release");

        // Keys '1' and 'D' together, ascending order
        pressed = 16'h8001;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h44);
        wait_keys(16'h8001, 6*SWEEP, "k0k15_keys");
        wait_idle(800, "k0k15_sent");
        pressed = 16'h0000;
        wait_keys(16'h0000, 6*SWEEP, "k0k15_release");

        // One-sweep glitch on the '2' key
        tx_seen   = 1'b0;
        keys_seen = 1'b0;
        pressed   = 16'h0002;
        repeat (SWEEP) @(negedge clk);
        pressed = 16'h0000;
        repeat (8*SWEEP) begin
            @(negedge clk);
            if (keys !== 16'h0000) keys_seen = 1'b1;
        end
        check("glitch_keys", keys_seen, 1'b0);
        check("glitch_tx", tx_seen, 1'b0);

        // '7' pressed, released, re-pressed during the '5' frame
        pressed = 16'h0020;
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h37);
        wait_keys(16'h0020, 6*SWEEP, "merge_k5");
        pressed = 16'h0120;
        wait_keys(16'h0120, 6*SWEEP, "merge_press1");
        pressed = 16'h0020;
        wait_keys(16'h0020, 6*SWEEP, "merge_release");
        pressed = 16'h0120;
        wait_keys(16'h0120, 6*SWEEP, "merge_press2");
        check("merge_in_frame", tx_busy, 1'b1);
        wait_idle(800, "merge_sent");
        tx_seen = 1'b0;
        pressed = 16'h0000;
        wait_keys(16'h0000, 6*SWEEP, "merge_release_all");
        repeat (12*SWEEP) @(negedge clk);
        check("merge_single_7", tx_seen, 1'b0);

        // Reset in the middle of a frame
        pressed = 16'h0001;
        wait_keys(16'h0001, 6*SWEEP, "rst_k0_keys");
        lat = 0;
        while (tx !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        repeat (5*BDIV + 8) @(negedge clk);
        check("rst_mid_busy", tx_busy, 1'b1);
        pressed = 16'h0000;
        rst_n   = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy_low", tx_busy, 1'b0);
        check("rst_mid_keys", keys, 16'h0000);
        check("rst_mid_col", col, 4'b1110);
        repeat (30) @(negedge clk);
        rst_n   = 1'b1;
        tx_seen = 1'b0;
        repeat (20*SWEEP) @(negedge clk);
        check("rst_no_resume", tx_seen, 1'b0);
        check("rst_keys_after", keys, 16'h0000);
        check("rst_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
